// File: rtl/regbank_mux.sv
// Register bank with one write port and two registered read ports.
// Reads bypass a same-cycle legal write; out-of-range accesses read as zero and raise a sticky err.
module regbank_mux #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter bit ZERO_REG = 1'b0,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  output logic             rvalid_a,
  input  logic             ren_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid_b,
  output logic             err
);

  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    raddr [2];
  logic [1:0]       ren;
  logic [1:0]       raddr_ok;
  logic             waddr_ok;
  logic             wr_ok;

  logic [WIDTH-1:0] rdata_q [2];
  logic [WIDTH-1:0] rdata_d [2];
  logic [1:0]       rvalid_q;
  logic [1:0]       rvalid_d;
  logic             err_q;
  logic             err_d;

  always_comb begin
    raddr[0] = raddr_a;
    raddr[1] = raddr_b;
    ren      = {ren_b, ren_a};
    waddr_ok = ({1'b0, waddr} < DEPTH_W);
    // A write to the hardwired-zero register is dropped without flagging an error.
    wr_ok    = wen && waddr_ok && !(ZERO_REG && (waddr == '0));
    err_d    = err_q | (wen & ~waddr_ok);
    raddr_ok = '0;
    rvalid_d = '0;
    for (int p = 0; p < 2; p++) begin
      raddr_ok[p] = ({1'b0, raddr[p]} < DEPTH_W);
      err_d       = err_d | (ren[p] & ~raddr_ok[p]);
      rvalid_d[p] = ren[p];
      rdata_d[p]  = rdata_q[p];
      if (ren[p]) begin
        rdata_d[p] = '0;
        if (!raddr_ok[p] || (ZERO_REG && (raddr[p] == '0))) begin
          rdata_d[p] = '0;
        end else if (wr_ok && (waddr == raddr[p])) begin
          rdata_d[p] = wdata;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (raddr[p] == AW'(i)) rdata_d[p] = mem_q[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ok && (waddr == AW'(i))) mem_q[i] <= wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) rdata_q[p] <= '0;
      rvalid_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) rdata_q[p] <= rdata_d[p];
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign rdata_a  = rdata_q[0];
  assign rdata_b  = rdata_q[1];
  assign rvalid_a = rvalid_q[0];
  assign rvalid_b = rvalid_q[1];
  assign err      = err_q;

endmodule

// File: tb/tb_regbank_mux.sv
// Bench for regbank_mux: three configurations share one stimulus stream and are
// checked every cycle against a per-configuration array model, plus literal expectations.
module tb_regbank_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wen;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic        ren_a;
  logic [3:0]  raddr_a;
  logic        ren_b;
  logic [3:0]  raddr_b;

  logic [2:0][15:0] rd_a;
  logic [2:0][15:0] rd_b;
  logic [2:0]       rv_a;
  logic [2:0]       rv_b;
  logic [2:0]       err_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // cfg0: DEPTH 16; cfg1: DEPTH 16 with hardwired zero; cfg2: DEPTH 12
  regbank_mux #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1'b0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren_a(ren_a), .raddr_a(raddr_a), .rdata_a(rd_a[0]), .rvalid_a(rv_a[0]),
    .ren_b(ren_b), .raddr_b(raddr_b), .rdata_b(rd_b[0]), .rvalid_b(rv_b[0]),
    .err(err_o[0])
  );

  regbank_mux #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1'b1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren_a(ren_a), .raddr_a(raddr_a), .rdata_a(rd_a[1]), .rvalid_a(rv_a[1]),
    .ren_b(ren_b), .raddr_b(raddr_b), .rdata_b(rd_b[1]), .rvalid_b(rv_b[1]),
    .err(err_o[1])
  );

  regbank_mux #(.WIDTH(16), .DEPTH(12), .ZERO_REG(1'b0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren_a(ren_a), .raddr_a(raddr_a), .rdata_a(rd_a[2]), .rvalid_a(rv_a[2]),
    .ren_b(ren_b), .raddr_b(raddr_b), .rdata_b(rd_b[2]), .rvalid_b(rv_b[2]),
    .err(err_o[2])
  );

  // ---------------- behavioural model ----------------
  logic [15:0] m_mem [3][16];
  logic [15:0] e_rd_a [3];
  logic [15:0] e_rd_b [3];
  logic        e_rv_a [3];
  logic        e_rv_b [3];
  logic        e_err  [3];

  function automatic int cfg_depth(int c);
    return (c == 2) ? 12 : 16;
  endfunction

  function automatic bit write_legal(int c, logic w, logic [3:0] wa);
    return w && (int'(wa) < cfg_depth(c)) && !((c == 1) && (wa == 4'd0));
  endfunction

  function automatic logic [15:0] expect_read(int c, logic [3:0] ra, bit wl,
                                              logic [3:0] wa, logic [15:0] wd);
    if (int'(ra) >= cfg_depth(c)) return 16'h0000;
    if ((c == 1) && (ra == 4'd0)) return 16'h0000;
    if (wl && (wa == ra)) return wd;
    return m_mem[c][ra];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit wl;
    for (int c = 0; c < 3; c++) begin
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) m_mem[c][i] = 16'h0000;
        e_rd_a[c] = 16'h0000;
        e_rd_b[c] = 16'h0000;
        e_rv_a[c] = 1'b0;
        e_rv_b[c] = 1'b0;
        e_err[c]  = 1'b0;
      end else begin
        wl = write_legal(c, wen, waddr);
        if (wen && (int'(waddr) >= cfg_depth(c))) e_err[c] = 1'b1;
        if (ren_a && (int'(raddr_a) >= cfg_depth(c))) e_err[c] = 1'b1;
        if (ren_b && (int'(raddr_b) >= cfg_depth(c))) e_err[c] = 1'b1;
        e_rv_a[c] = ren_a;
        e_rv_b[c] = ren_b;
        if (ren_a) e_rd_a[c] = expect_read(c, raddr_a, wl, waddr, wdata);
        if (ren_b) e_rd_b[c] = expect_read(c, raddr_b, wl, waddr, wdata);
        if (wl) m_mem[c][waddr] = wdata;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      check($sformatf("cfg%0d rdata_a", c), rd_a[c], e_rd_a[c]);
      check($sformatf("cfg%0d rdata_b", c), rd_b[c], e_rd_b[c]);
      check($sformatf("cfg%0d rvalid_a", c), {15'b0, rv_a[c]}, {15'b0, e_rv_a[c]});
      check($sformatf("cfg%0d rvalid_b", c), {15'b0, rv_b[c]}, {15'b0, e_rv_b[c]});
      check($sformatf("cfg%0d err", c), {15'b0, err_o[c]}, {15'b0, e_err[c]});
    end
  end

  task automatic check_all_zero(input string tag);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("%s cfg%0d rdata_a", tag, c), rd_a[c], 16'h0000);
      check($sformatf("%s cfg%0d rdata_b", tag, c), rd_b[c], 16'h0000);
      check($sformatf("%s cfg%0d rvalids", tag, c), {14'b0, rv_b[c], rv_a[c]}, 16'h0000);
      check($sformatf("%s cfg%0d err", tag, c), {15'b0, err_o[c]}, 16'h0000);
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; applies one cycle of inputs and returns at the next posedge+1.
  task automatic step(input logic w, input logic [3:0] wa, input logic [15:0] wd,
                      input logic ea, input logic [3:0] ra,
                      input logic eb, input logic [3:0] rb);
    wen = w; waddr = wa; wdata = wd;
    ren_a = ea; raddr_a = ra;
    ren_b = eb; raddr_b = rb;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 4'd0);
  endtask

  // Reset pulse placed between edges; outputs must clear without waiting for a clock.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    #1;
    rst_n = 1'b1;
    wen = 1'b0; ren_a = 1'b0; ren_b = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    wen = 1'b0; waddr = '0; wdata = '0;
    ren_a = 1'b0; raddr_a = '0; ren_b = 1'b0; raddr_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("in reset");
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("after release");

    // read of never-written register
    step(1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 1'b0, 4'd0);
    check("read5 rdata_a", rd_a[0], 16'h0000);
    check("read5 rvalid_a", {15'b0, rv_a[0]}, 16'h0001);

    // write then read
    step(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 1'b0, 4'd0);
    check("idle rvalid_a", {15'b0, rv_a[0]}, 16'h0000);
    step(1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b0, 4'd0);
    check("wr3 rdata_a", rd_a[0], 16'hBEEF);
    step(1'b1, 4'd15, 16'h1234, 1'b0, 4'd0, 1'b0, 4'd0);
    check("wr15 cfg2 err", {15'b0, err_o[2]}, 16'h0001);
    step(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b1, 4'd15);
    check("wr15 rdata_b", rd_b[0], 16'h1234);
    check("wr15 rdata_a held", rd_a[0], 16'hBEEF);
    check("wr15 cfg2 rdata_b", rd_b[2], 16'h0000);

    // same-cycle bypass on both ports
    step(1'b1, 4'd7, 16'hA5A5, 1'b1, 4'd7, 1'b1, 4'd7);
    check("bypass rdata_a", rd_a[0], 16'hA5A5);
    check("bypass rdata_b", rd_b[0], 16'hA5A5);
    step(1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 1'b0, 4'd0);
    check("later read7", rd_a[0], 16'hA5A5);

    // hardwired zero register
    step(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 1'b0, 4'd0);
    check("zr read0", rd_a[1], 16'h0000);
    check("zr err", {15'b0, err_o[1]}, 16'h0000);
    check("cfg0 read0", rd_a[0], 16'hFFFF);
    step(1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 1'b1, 4'd0);
    check("zr bypass a", rd_a[1], 16'h0000);
    check("zr bypass b", rd_b[1], 16'h0000);

    // out of range on the 12-deep bank
    pulse_reset("oor reset");
    step(1'b1, 4'd13, 16'h5555, 1'b0, 4'd0, 1'b0, 4'd0);
    check("oor wr err", {15'b0, err_o[2]}, 16'h0001);
    check("oor wr cfg0 err", {15'b0, err_o[0]}, 16'h0000);
    step(1'b0, 4'd0, 16'h0000, 1'b1, 4'd14, 1'b1, 4'd13);
    check("oor rd rdata_a", rd_a[2], 16'h0000);
    check("oor rd rvalid_a", {15'b0, rv_a[2]}, 16'h0001);
    check("cfg0 rd13", rd_b[0], 16'h5555);
    repeat (3) idle();
    check("oor err sticky", {15'b0, err_o[2]}, 16'h0001);

    // randomized traffic with occasional between-edge resets
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] wa;
      wa = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), wa, 16'($urandom),
           1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 99) == 0) pulse_reset("rand reset");
    end

    // err is cleared only by reset
    step(1'b1, 4'd12, 16'h5555, 1'b0, 4'd0, 1'b0, 4'd0);
    repeat (2) idle();
    check("err before reset", {15'b0, err_o[2]}, 16'h0001);
    pulse_reset("err reset");
    check("err after reset", {15'b0, err_o[2]}, 16'h0000);

    // in-flight reads discarded by a mid-operation reset
    step(1'b1, 4'd9, 16'h9999, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b0, 4'd0, 16'h0000, 1'b1, 4'd9, 1'b1, 4'd3);
    check("pre reset read9", rd_a[0], 16'h9999);
    wen = 1'b0; ren_a = 1'b1; raddr_a = 4'd9; ren_b = 1'b1; raddr_b = 4'd9;
    #1;
    pulse_reset("mid reset");
    step(1'b0, 4'd0, 16'h0000, 1'b1, 4'd9, 1'b1, 4'd9);
    check("post reset read9 a", rd_a[0], 16'h0000);
    check("post reset read9 b", rd_b[0], 16'h0000);
    check("post reset rvalid", {15'b0, rv_a[0]}, 16'h0001);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regbank_mux.md
# regbank_mux

Parametrised register bank with one write port and two independent registered read ports. It generalises the datapath's fixed 16-way, 16-bit operand selection into a storage-plus-selection block of configurable width and depth. It has write-to-read bypass, an optional hardwired-zero register and out-of-range protection. It sits between the ALU result bus and the ALU operand inputs; the controller issues one write and up to two reads per cycle.

## Interface
- WIDTH, 16, data width in bits (1..64)
- DEPTH, 16, number of registers (2..64, need not be a power of two)
- AW, clog2(DEPTH), address width (derived, not overridden)
- ZERO_REG, 0, when 1 register 0 always reads 0 and ignores writes

Ports:
- clk  in  1  rising-edge clock for all state
- rst_n  in  1  asynchronous, active-low reset
- wen  in  1  write enable
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- ren_a  in  1  read request, port A
- raddr_a  in  AW  read address, port A
- rdata_a  out  WIDTH  registered read data, port A
- rvalid_a  out  1  rdata_a holds the result of a request issued last cycle
- ren_b, raddr_b, rdata_b, rvalid_b: identical to the port A signals, for port B
- err  out  1  sticky flag: an out-of-range address was presented with its enable high

## Operation
- Storage: DEPTH × WIDTH flops.
- Write: on a rising edge with wen=1 and waddr<DEPTH, reg[waddr] takes wdata.
  - If waddr≥DEPTH, the write is dropped and err is set.
  - If ZERO_REG=1 and waddr=0, the write is dropped silently; err is not set.
- Read: on a rising edge with ren_x=1, rdata_x is loaded with the selected value and rvalid_x goes to 1. The selected value is, in priority order:
  - 0 if raddr_x≥DEPTH; err is also set.
  - 0 if ZERO_REG=1 and raddr_x=0.
  - wdata (bypass) if wen=1 and waddr=raddr_x and the write is legal.
  - Otherwise reg[raddr_x] as it was before the edge.
- Idle read port: on an edge with ren_x=0, rdata_x holds its previous value and rvalid_x goes to 0.
- Independent ports: A and B may read the same address in the same cycle; both receive identical data.
- err: set by any out-of-range enabled access. It is cleared only by reset.
- Reset (rst_n=0, asynchronous, effective immediately regardless of clk):
  - all registers = 0
  - rdata_a = rdata_b = 0
  - rvalid_a = rvalid_b = 0
  - err = 0
- Reset deassertion: the first edge after deassertion is a normal cycle. A reset asserted mid-operation discards any in-flight read, and rvalid goes to 0 immediately.

## Timing
- Read latency is exactly 1 cycle: a request sampled at edge N presents data and rvalid at edge N, which the consumer samples at edge N+1.
- Write latency is 1 cycle. A read issued in the same cycle as a write to the same address sees the new data through the bypass, so there is no read-after-write hazard bubble.
- Throughput: one write plus two reads every cycle, with no stalls and no back-pressure.
- Inputs are sampled only at rising clk edges. Outputs change only at edges or on reset assertion.
- The combinational path runs from raddr/waddr/wdata through the DEPTH:1 select and the bypass compare to the rdata flops. Synthesis constrains it as a single-cycle path.

## Test plan
- Reset/idle:
  - Hold rst_n=0, then release it. All outputs must be 0.
  - Issue ren_a=1 with raddr_a=5. The next cycle must give rdata_a=0x0000 and rvalid_a=1.
- Write then read:
  - Write 0xBEEF to address 3, then read A=3 on the following cycle. Expect rdata_a=0xBEEF.
  - Write 0x1234 to address 15 and read B=15. Expect rdata_b=0x1234 while rdata_a is unchanged.
- Bypass:
  - In one cycle, set wen=1, waddr=7, wdata=0xA5A5 and ren_a=ren_b=1 with raddr_a=raddr_b=7. Next cycle, both rdata values must be 0xA5A5.
  - A later read of address 7 must also return 0xA5A5.
- ZERO_REG=1:
  - Write 0xFFFF to address 0, then read address 0. Expect rdata=0 and err=0, including through the same-cycle bypass case.
- Out of range (DEPTH=12):
  - Write 0x5555 to address 13. Expect err=1 and no register changed.
  - Read A=14. Expect rdata_a=0 and rvalid_a=1.
  - err must stay 1 until rst_n is pulsed.
- Mid-operation reset:
  - Start back-to-back reads, then pulse rst_n low between edges. rvalid and rdata must drop to 0 immediately.
  - After release, reading any address previously written returns 0.
